// File: rtl/mem_modport.sv
// Memory-side endpoint of the mem_ifa link: 32x8 flop array with clocked write
// and combinational, read-gated output.
`timescale 1ns/1ns
module mem_modport #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;
  logic              rd_en;

  // A simultaneous read and write is illegal: both are dropped.
  assign wr_en = write & ~read;
  assign rd_en = read & ~write;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[addr] = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign data_out = rd_en ? mem_q[addr] : '0;

endmodule

// File: tb/tb_mem_modport.sv
// Scoreboard bench for mem_modport: stimulus queues expected read data, a
// monitor samples data_out 7 ns after each request and compares.
`timescale 1ns/1ns
module tb_mem_modport;

  typedef struct {
    string      name;
    logic [4:0] addr;
    logic [7:0] exp;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       chk_req;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  mem_modport #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: sample 7 ns after the request is presented on the falling edge.
  always begin
    @(negedge clk);
    #7;
    if (chk_req) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got=%h required=<queued entry>", data_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (data_out !== e.exp) begin
          errors++;
          $display("FAIL %s addr=%0d got=%h required=%h", e.name, e.addr, data_out, e.exp);
        end
      end
    end
  end

  task automatic push_exp(input string name, input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    e.name = name;
    e.addr = a;
    e.exp  = d;
    sb_q.push_back(e);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    chk_req = 1'b0;
    read    = 1'b0;
    write   = 1'b1;
    addr    = a;
    data_in = d;
  endtask

  task automatic do_read(input string name, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    push_exp(name, a, d);
    read    = 1'b1;
    write   = 1'b0;
    addr    = a;
    chk_req = 1'b1;
  endtask

  task automatic do_idle();
    @(negedge clk);
    chk_req = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    chk_req = 1'b0;
    rst_n   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = 5'd0;
    data_in = 8'h00;

    // Reset held two cycles; output gated to zero while idle.
    @(negedge clk);
    push_exp("reset_idle_out", 5'd0, 8'h00);
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 32; i++) do_read("reset_clear", 5'(i), 8'h00);

    // Single write/read with neighbours untouched.
    do_write(5'd3, 8'hA5);
    do_read("single_rd", 5'd3, 8'hA5);
    do_read("single_nb_lo", 5'd2, 8'h00);
    do_read("single_nb_hi", 5'd4, 8'h00);

    // Full sweep, read back in reverse.
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'(i * 3));
    do_read("sweep_31", 5'd31, 8'd93);
    do_read("sweep_0", 5'd0, 8'd0);
    for (int i = 31; i >= 0; i--) do_read("sweep", 5'(i), 8'(i * 3));

    // Read gating.
    do_write(5'd31, 8'h3C);
    @(negedge clk);
    push_exp("gate_read0", 5'd31, 8'h00);
    read    = 1'b0;
    write   = 1'b0;
    addr    = 5'd31;
    chk_req = 1'b1;
    do_read("gate_read1", 5'd31, 8'h3C);

    // Collision: write suppressed, output zero.
    do_write(5'd7, 8'h11);
    @(negedge clk);
    push_exp("collision_out", 5'd7, 8'h00);
    read    = 1'b1;
    write   = 1'b1;
    addr    = 5'd7;
    data_in = 8'hFF;
    chk_req = 1'b1;
    do_read("collision_hold", 5'd7, 8'h11);

    // Reset mid-operation discards the concurrent write.
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'hFF);
    do_read("prefill_10", 5'd10, 8'hFF);
    @(negedge clk);
    push_exp("rst_write_out", 5'd10, 8'h00);
    rst_n   = 1'b0;
    read    = 1'b0;
    write   = 1'b1;
    addr    = 5'd10;
    data_in = 8'h55;
    chk_req = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    chk_req = 1'b0;
    write   = 1'b0;
    for (int i = 0; i < 32; i++) do_read("rst_mid_clear", 5'(i), 8'h00);

    do_idle();
    @(negedge clk);
    #10;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d required=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_modport.md
# mem_modport

32-word × 8-bit single-port synchronous-write, asynchronous-read memory. It is the memory-side endpoint of the `mem_ifa` interface (`mem_to_test` modport) and sits opposite the test/controller side, which drives `read`/`write`/`addr`/`data_in` and samples `data_out`. Writes are clocked. Reads are combinational, so data is valid well inside one clock period. Timeunit/timeprecision: 1ns/1ns.

## Interface
Parameters:
- `ADDR_W`, default 5: address width; depth = 2**ADDR_W (32).
- `DATA_W`, default 8: word width.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `read`  input  1  read enable.
- `write`  input  1  write enable.
- `addr`  input  ADDR_W  word address, 0..31.
- `data_in`  input  DATA_W  write data.
- `data_out`  output  DATA_W  read data.

## Operation
- Storage: array `mem[0:31]` of 8-bit words, held in flops.
- Reset:
  - `rst_n`=0 sampled at a rising edge clears all 32 words to 8'h00 in that cycle.
  - Reset has priority over write. No write occurs in a reset cycle.
- Write:
  - At a rising edge with `rst_n`=1, `write`=1 and `read`=0, `mem[addr]` <= `data_in`.
  - All other locations are unchanged.
- Read:
  - `data_out` = `mem[addr]` whenever `read`=1 and `write`=0. This path is purely combinational from `addr`/`read` and the array.
  - `data_out` = 8'h00 whenever `read`=0. It is never X or Z.
- Simultaneous `read`=1 and `write`=1 is an illegal request:
  - The write is suppressed and memory is unchanged.
  - `data_out` = 8'h00.
- `read`=0, `write`=0: idle. Memory holds, `data_out` = 8'h00.
- Address range: all 5-bit values are valid. There is no wrap or out-of-range case.
- Outputs under reset:
  - `data_out` follows the read rule above.
  - After the reset edge, every read returns 8'h00.

## Timing
- Write latency: data is stored at the first rising edge where the write conditions hold. A read of that address returns the new value immediately after that edge.
- Read latency: zero cycles, combinational.
  - `data_out` must settle within 7 ns of `addr`/`read` changing.
  - Controllers sample `data_out` 7 ns after presenting `addr` with `read`=1.
- Controller convention: `addr`, `data_in`, `read` and `write` change away from the rising edge (e.g., on the falling edge or mid-cycle), giving full setup before the capturing edge.
- Read-during-write: not possible, because of the collision rule above.
- Reset mid-operation:
  - A write presented in the same cycle as `rst_n`=0 is lost.
  - A read in progress returns the pre-reset contents until the reset edge, then 8'h00.
- No handshake or acknowledge. Every legal request completes in one cycle.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles, release, then read addresses 0..31 -> every `data_out` = 8'h00.
- Single write/read: write 8'hA5 to addr 3, then read addr 3 -> 8'hA5; read addr 2 and addr 4 -> 8'h00.
- Full sweep: write `data = addr*3` to addr 0..31, then read back in reverse order -> each read returns `addr*3` (e.g., addr 31 -> 8'd93); zero mismatches; printstatus reports 0 errors.
- Idle and read-gating: after writing 8'h3C to addr 31, set `read`=0 with addr 31 -> `data_out` = 8'h00; assert `read`=1 -> 8'h3C within 7 ns.
- Collision: write 8'h11 to addr 7, then drive `read`=1, `write`=1, `data_in`=8'hFF at addr 7 for one edge -> `data_out` = 8'h00 during collision; a subsequent clean read of addr 7 -> 8'h11.
- Reset mid-operation: fill addr 0..31 with 8'hFF, then pulse `rst_n`=0 for one edge concurrent with a write of 8'h55 to addr 10 -> all 32 reads, including addr 10, return 8'h00.
